// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic tile and its edge feeder.
package systolic_pkg;
  localparam int N          = 8;
  localparam int DW         = 16;
  localparam int SEQ_LEN    = 3 * N - 1;
  localparam int STREAM_LEN = SEQ_LEN + 2;
  localparam int CW         = $clog2(STREAM_LEN);
  localparam int KW         = $clog2(N) + 1;
  localparam int IW         = $clog2(N);

  typedef logic [DW-1:0] elem_t;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} feed_state_t;
endpackage

// File: rtl/skew_lane_mux.sv
// One skewed edge lane: picks vals[c-LANE] inside the N-wide window, zero elsewhere.
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int LANE = 0
) (
  input  elem_t         vals [N],
  input  logic [CW-1:0] c,
  output elem_t         sel
);
  localparam logic signed [CW+1:0] LANE_S = (CW+2)'(LANE);
  localparam logic signed [CW+1:0] N_S    = (CW+2)'(N);

  logic signed [CW+1:0] off;

  // Widened signed offset keeps c-LANE from wrapping below zero
  always_comb begin
    off = $signed({2'b00, c}) - LANE_S;
    if (!off[CW+1] && (off < N_S)) begin
      sel = vals[off[IW-1:0]];
    end else begin
      sel = '0;
    end
  end
endmodule

// File: rtl/edge_skew_feeder.sv
// Buffers one operand pair as N k-slices, then streams skewed, zero-padded
// row/column edges into the systolic tile with an aligned enable window.
module edge_skew_feeder (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   IN_VALID,
  output logic                                   IN_READY,
  input  logic [systolic_pkg::N*systolic_pkg::DW-1:0] A_IN,
  input  logic [systolic_pkg::N*systolic_pkg::DW-1:0] B_IN,
  output logic [systolic_pkg::N*systolic_pkg::DW-1:0] R_X,
  output logic [systolic_pkg::N*systolic_pkg::DW-1:0] C_X,
  output logic                                   TILE_EN,
  output logic                                   BUSY,
  output logic                                   DONE
);
  import systolic_pkg::*;

  // Aliases avoid the clash between the DONE state and the DONE port
  localparam feed_state_t ST_IDLE   = systolic_pkg::IDLE;
  localparam feed_state_t ST_LOAD   = systolic_pkg::LOAD;
  localparam feed_state_t ST_STREAM = systolic_pkg::STREAM;
  localparam feed_state_t ST_DONE   = systolic_pkg::DONE;

  feed_state_t   state, state_nxt;
  logic [KW-1:0] k;
  logic [CW-1:0] c;
  elem_t         a_buf [N][N];
  elem_t         b_buf [N][N];
  elem_t         b_col [N][N];
  elem_t         r_sel [N];
  elem_t         c_sel [N];
  logic          xfer;
  logic          last_slice;
  logic          streaming;

  assign IN_READY   = (state == ST_IDLE) || (state == ST_LOAD);
  assign BUSY       = (state != ST_IDLE);
  assign xfer       = IN_VALID && IN_READY;
  assign last_slice = (k == KW'(N - 1));
  assign streaming  = (state == ST_STREAM);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (xfer) state_nxt = last_slice ? ST_STREAM : ST_LOAD;
        else      state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (xfer && last_slice) state_nxt = ST_STREAM;
        else                    state_nxt = ST_LOAD;
      end
      ST_STREAM: begin
        if (c == CW'(STREAM_LEN - 1)) state_nxt = ST_DONE;
        else                          state_nxt = ST_STREAM;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      k     <= '0;
      c     <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) k <= last_slice ? '0 : k + KW'(1);
      else      k <= k;
      if (streaming && (c != CW'(STREAM_LEN - 1))) c <= c + CW'(1);
      else                                          c <= '0;
    end
  end

  // Operand storage is pure datapath; stale contents are always overwritten before use
  always_ff @(posedge CLK) begin
    if (xfer) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i][k[IW-1:0]] <= A_IN[i*DW +: DW];
        b_buf[k[IW-1:0]][i] <= B_IN[i*DW +: DW];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      for (int r = 0; r < N; r++) begin
        b_col[j][r] = b_buf[r][j];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_mux #(.LANE(g)) u_row (.vals(a_buf[g]), .c(c), .sel(r_sel[g]));
    skew_lane_mux #(.LANE(g)) u_col (.vals(b_col[g]), .c(c), .sel(c_sel[g]));
  end

  // Outputs lag the state by one edge so the enable and cycle-c data appear together
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      R_X     <= '0;
      C_X     <= '0;
      TILE_EN <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      TILE_EN <= streaming;
      DONE    <= (state == ST_DONE);
      for (int i = 0; i < N; i++) begin
        R_X[i*DW +: DW] <= streaming ? r_sel[i] : '0;
        C_X[i*DW +: DW] <= streaming ? c_sel[i] : '0;
      end
    end
  end
endmodule

// File: tb/tb_edge_skew_feeder.sv
// Directed bench for edge_skew_feeder: ramp, backpressure, distinct values,
// busy rejection, mid-stream reset and back-to-back operand pairs.
module tb_edge_skew_feeder;
  import systolic_pkg::*;

  localparam int VW = N * DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [VW-1:0] A_IN;
  logic [VW-1:0] B_IN;
  logic [VW-1:0] R_X;
  logic [VW-1:0] C_X;
  logic          TILE_EN;
  logic          BUSY;
  logic          DONE;

  int            a_mat [N][N];
  int            b_mat [N][N];
  logic [VW-1:0] rx_log [STREAM_LEN];
  logic [VW-1:0] cx_log [STREAM_LEN];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            s1, s2;

  edge_skew_feeder dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A_IN(A_IN), .B_IN(B_IN), .R_X(R_X), .C_X(C_X),
    .TILE_EN(TILE_EN), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [VW-1:0] exp_r(input int c);
    logic [VW-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (c - i >= 0 && c - i < N) v[i*DW +: DW] = DW'(a_mat[i][c-i]);
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_c(input int c);
    logic [VW-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (c - j >= 0 && c - j < N) v[j*DW +: DW] = DW'(b_mat[c-j][j]);
    return v;
  endfunction

  task automatic set_ramp();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_mat[i][k] = k + 1;
        b_mat[k][i] = k + 1;
      end
  endtask

  task automatic set_distinct();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_mat[i][k] = 16 * i + k;
        b_mat[k][i] = 256 + 16 * k + i;
      end
  endtask

  task automatic set_garbage();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_mat[i][k] = 16'hdea0 + i + k;
        b_mat[k][i] = 16'hbe00 + i * k;
      end
  endtask

  // Offers nsl slices; with bp, IN_VALID follows 1,0,0,1,0,0,...
  task automatic feed(input bit bp, input int nsl);
    int   k = 0;
    int   n = 0;
    logic vld, rdy;
    while (k < nsl && n < 100) begin
      @(negedge CLK);
      vld = bp ? (n % 3 == 0) : 1'b1;
      n++;
      IN_VALID = vld;
      for (int i = 0; i < N; i++) begin
        A_IN[i*DW +: DW] = DW'(a_mat[i][k]);
        B_IN[i*DW +: DW] = DW'(b_mat[k][i]);
      end
      rdy = IN_READY;
      @(posedge CLK);
      if (vld && rdy) k++;
    end
    #1 IN_VALID = 1'b0;
    if (k != nsl) check("feed_timeout", VW'(k), VW'(nsl));
  endtask

  // Starts 1ns after the last transfer edge
  task automatic run_stream(input bit hold, input int rst_at, input bit tail, output int start);
    start = -1;
    check("en_pre", VW'(TILE_EN), VW'(1'b0));
    for (int c = 0; c < STREAM_LEN; c++) begin
      if (hold) begin
        IN_VALID = 1'b1;
        A_IN     = '1;
        B_IN     = '1;
      end
      @(posedge CLK); #1;
      if (c == 0) start = cyc;
      check($sformatf("en c=%0d", c), VW'(TILE_EN), VW'(1'b1));
      check($sformatf("rx c=%0d", c), R_X, exp_r(c));
      check($sformatf("cx c=%0d", c), C_X, exp_c(c));
      rx_log[c] = R_X;
      cx_log[c] = C_X;
      if (hold) check($sformatf("rdy_busy c=%0d", c), VW'(IN_READY), VW'(1'b0));
      if (c == rst_at) begin
        RST = 1'b1;
        #1;
        check("rst_en", VW'(TILE_EN), VW'(1'b0));
        check("rst_rx", R_X, '0);
        check("rst_cx", C_X, '0);
        check("rst_busy", VW'(BUSY), VW'(1'b0));
        check("rst_rdy", VW'(IN_READY), VW'(1'b1));
        return;
      end
    end
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    check("done_hi", VW'(DONE), VW'(1'b1));
    check("en_off", VW'(TILE_EN), VW'(1'b0));
    check("rdy_after", VW'(IN_READY), VW'(1'b1));
    check("rx_off", R_X, '0);
    if (tail) begin
      @(posedge CLK); #1;
      check("done_lo", VW'(DONE), VW'(1'b0));
      check("busy_idle", VW'(BUSY), VW'(1'b0));
    end
  endtask

  initial begin
    RST      = 1'b1;
    IN_VALID = 1'b0;
    A_IN     = '0;
    B_IN     = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_rdy0", VW'(IN_READY), VW'(1'b1));
    check("rst_en0", VW'(TILE_EN), VW'(1'b0));
    check("rst_busy0", VW'(BUSY), VW'(1'b0));
    check("rst_done0", VW'(DONE), VW'(1'b0));
    check("rst_rx0", R_X, '0);
    check("rst_cx0", C_X, '0);
    @(negedge CLK) RST = 1'b0;

    // Ramp followed immediately by distinct values
    set_ramp();
    feed(1'b0, N);
    run_stream(1'b0, -1, 1'b0, s1);
    check("ramp_r0_c0", VW'(rx_log[0][0 +: DW]), VW'(16'd1));
    check("ramp_r0_c7", VW'(rx_log[7][0 +: DW]), VW'(16'd8));
    check("ramp_r7_c7", VW'(rx_log[7][7*DW +: DW]), VW'(16'd1));
    check("ramp_r7_c14", VW'(rx_log[14][7*DW +: DW]), VW'(16'd8));
    check("ramp_zero_c15", rx_log[15], '0);
    check("ramp_c4_c3", VW'(cx_log[3][4*DW +: DW]), VW'(16'd0));
    check("ramp_c2_c6", VW'(cx_log[6][2*DW +: DW]), VW'(16'd5));
    set_distinct();
    feed(1'b0, N);
    run_stream(1'b0, -1, 1'b1, s2);
    check("dist_r3_c5", VW'(rx_log[5][3*DW +: DW]), VW'(16'h0032));
    check("dist_c2_c9", VW'(cx_log[9][2*DW +: DW]), VW'(16'h0172));
    check("b2b_period", VW'(s2 - s1), VW'(34));

    // Backpressure
    set_ramp();
    feed(1'b1, N);
    run_stream(1'b0, -1, 1'b1, s1);

    // Busy rejection, then a clean reload
    set_distinct();
    feed(1'b0, N);
    run_stream(1'b1, -1, 1'b1, s1);
    set_ramp();
    feed(1'b0, N);
    run_stream(1'b0, -1, 1'b1, s1);

    // Reset at c=10, partial load discarded, fresh load
    feed(1'b0, N);
    run_stream(1'b0, 10, 1'b0, s1);
    @(negedge CLK) RST = 1'b0;
    #1;
    check("rel_rdy", VW'(IN_READY), VW'(1'b1));
    check("rel_en", VW'(TILE_EN), VW'(1'b0));
    set_garbage();
    feed(1'b0, 3);
    check("partial_busy", VW'(BUSY), VW'(1'b1));
    RST = 1'b1;
    #2 RST = 1'b0;
    check("partial_drop", VW'(BUSY), VW'(1'b0));
    set_distinct();
    feed(1'b0, N);
    run_stream(1'b0, -1, 1'b1, s1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
